// File: rtl/seq_gen_prog_if.sv
// seq_gen_prog_if: control, pattern-load and serial-output bundle for seq_gen_prog.
// The frame output exists only when SEQ_GEN_FRAME_EN is defined.
interface seq_gen_prog_if #(
    parameter int IDX_W = 3
);
    localparam int DEPTH = 2 ** IDX_W;

    logic             en;
    logic             start;
    logic             stop;
    logic             mode;
    logic             load;
    logic [DEPTH-1:0] pat_in;
    logic [IDX_W-1:0] len_in;
    logic             f;
    logic [IDX_W-1:0] idx;
    logic             busy;
    logic             done;
`ifdef SEQ_GEN_FRAME_EN
    logic             frame;
`endif

    // Controller side: drives commands and pattern, observes the serial stream
    modport master (
        output en, start, stop, mode, load, pat_in, len_in,
`ifdef SEQ_GEN_FRAME_EN
        input  frame,
`endif
        input  f, idx, busy, done
    );

    // Generator side
    modport slave (
        input  en, start, stop, mode, load, pat_in, len_in,
`ifdef SEQ_GEN_FRAME_EN
        output frame,
`endif
        output f, idx, busy, done
    );
endinterface

// File: rtl/seq_gen_prog.sv
// seq_gen_prog: programmable serial sequence generator.
// Emits a DEPTH-bit pattern LSB first, one bit per enabled clock, over a
// programmable length, in continuous (wrap) or one-shot (done pulse) mode.
// Optional feature macro: SEQ_GEN_FRAME_EN adds a frame pulse on the last bit.
module seq_gen_prog #(
    parameter int          IDX_W   = 3,
    parameter logic [31:0] RST_PAT = 32'h19
) (
    input  logic          clk,
    input  logic          rst,
    seq_gen_prog_if.slave bus
);
    localparam int DEPTH = 2 ** IDX_W;
    // Reset pattern truncated or zero-extended to the pattern width
    localparam logic [DEPTH-1:0] RST_PAT_D = DEPTH'(RST_PAT);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state;
    logic [DEPTH-1:0] pat;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] idx;
    logic             mode_r;
    logic             f;
    logic             done;
`ifdef SEQ_GEN_FRAME_EN
    logic             frame;
`endif

    // Sequencer FSM: pattern/length load, run control and serial output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            pat    <= RST_PAT_D;
            last   <= IDX_W'(DEPTH - 1);
            idx    <= '0;
            mode_r <= 1'b0;
            f      <= 1'b0;
            done   <= 1'b0;
`ifdef SEQ_GEN_FRAME_EN
            frame  <= 1'b0;
`endif
        end else begin
`ifdef SEQ_GEN_FRAME_EN
            frame <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    f    <= 1'b0;
                    done <= 1'b0;
                    // load and start together: the new run sees the new pattern
                    if (bus.load) begin
                        pat  <= bus.pat_in;
                        last <= bus.len_in;
                    end
                    if (bus.start) begin
                        idx    <= '0;
                        mode_r <= bus.mode;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    done <= 1'b0;
                    if (bus.stop) begin
                        // Abort: no done pulse
                        state <= IDLE;
                        f     <= 1'b0;
                        idx   <= '0;
                    end else if (bus.en) begin
                        f <= pat[idx];
                        if (idx != last) begin
                            idx <= idx + IDX_W'(1);
                        end else begin
                            idx <= '0;
`ifdef SEQ_GEN_FRAME_EN
                            frame <= 1'b1;
`endif
                            if (mode_r) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.f    = f;
    assign bus.idx  = idx;
    assign bus.busy = (state == RUN);
    assign bus.done = done;
`ifdef SEQ_GEN_FRAME_EN
    assign bus.frame = frame;
`endif

endmodule

// File: tb/tb_seq_gen_prog.sv
// tb_seq_gen_prog: directed self-checking bench for seq_gen_prog.
// Expected per-edge outputs are queued when stimulus is driven and popped
// when the DUT output is sampled 1 time unit after the edge.
module tb_seq_gen_prog;
    localparam int IDX_W = 3;

    typedef struct {
        string      tag;
        logic       f;
        logic       busy;
        logic       done;
        logic [2:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    seq_gen_prog_if #(.IDX_W(IDX_W)) bus ();

    seq_gen_prog #(.IDX_W(IDX_W), .RST_PAT(32'h19)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // One comparison: counts it and reports any difference
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the expectation for the coming edge, advance, then pop and compare
    task automatic cyc(input string tag, input logic ef, input logic eb,
                       input logic ed, input logic [2:0] ei);
        exp_t e;
        sb.push_back('{tag, ef, eb, ed, ei});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".f"},    32'(bus.f),    32'(e.f));
        chk({e.tag, ".busy"}, 32'(bus.busy), 32'(e.busy));
        chk({e.tag, ".done"}, 32'(bus.done), 32'(e.done));
        chk({e.tag, ".idx"},  32'(bus.idx),  32'(e.idx));
    endtask

    task automatic idle_inputs();
        bus.en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0;
        bus.load = 1'b0; bus.pat_in = '0; bus.len_in = '0;
    endtask

    initial begin
        logic [7:0] p;
        idle_inputs();

        // Reset state
        #2;
        chk("rst.f", 32'(bus.f), 0);
        chk("rst.busy", 32'(bus.busy), 0);
        chk("rst.done", 32'(bus.done), 0);
        chk("rst.idx", 32'(bus.idx), 0);
`ifdef SEQ_GEN_FRAME_EN
        chk("rst.frame", 32'(bus.frame), 0);
`endif
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // Default pattern, continuous: 1,0,0,1,1,0,0,0,1,0
        p = 8'h19;
        bus.start = 1'b1; bus.mode = 1'b0; bus.en = 1'b1;
        cyc("def.start", 1'b0, 1'b1, 1'b0, 3'd0);
        bus.start = 1'b0;
        for (int k = 0; k < 10; k++)
            cyc($sformatf("def.bit%0d", k), p[k % 8], 1'b1, 1'b0, 3'((k + 1) % 8));
        bus.stop = 1'b1;
        cyc("def.stop", 1'b0, 1'b0, 1'b0, 3'd0);
        bus.stop = 1'b0;

        // One-shot, pattern A5, length 4: 1,0,1,0 then done
        p = 8'hA5;
        bus.load = 1'b1; bus.pat_in = p; bus.len_in = 3'd3;
        bus.start = 1'b1; bus.mode = 1'b1;
        cyc("one.start", 1'b0, 1'b1, 1'b0, 3'd0);
        bus.load = 1'b0; bus.start = 1'b0;
        for (int k = 0; k < 3; k++)
            cyc($sformatf("one.bit%0d", k), p[k], 1'b1, 1'b0, 3'(k + 1));
        cyc("one.last", p[3], 1'b0, 1'b1, 3'd0);
        cyc("one.after", 1'b0, 1'b0, 1'b0, 3'd0);

        // Enable gaps, continuous, same pattern (last = 3)
        bus.start = 1'b1; bus.mode = 1'b0;
        cyc("gap.start", 1'b0, 1'b1, 1'b0, 3'd0);
        bus.start = 1'b0;
        cyc("gap.en1", p[0], 1'b1, 1'b0, 3'd1);
        bus.en = 1'b0;
        cyc("gap.en0a", p[0], 1'b1, 1'b0, 3'd1);
        cyc("gap.en0b", p[0], 1'b1, 1'b0, 3'd1);
        bus.en = 1'b1;
        cyc("gap.en1b", p[1], 1'b1, 1'b0, 3'd2);

        // Controls ignored in RUN: a new pattern/length/mode must not take effect
        bus.load = 1'b1; bus.pat_in = 8'h00; bus.len_in = 3'd0;
        bus.start = 1'b1; bus.mode = 1'b1;
        cyc("ign.b2", p[2], 1'b1, 1'b0, 3'd3);
        cyc("ign.b3", p[3], 1'b1, 1'b0, 3'd0);
        cyc("ign.b0", p[0], 1'b1, 1'b0, 3'd1);
        bus.load = 1'b0; bus.start = 1'b0; bus.mode = 1'b0;
        bus.stop = 1'b1;
        cyc("ign.stop", 1'b0, 1'b0, 1'b0, 3'd0);
        bus.stop = 1'b0;

        // Length 1 continuous: f constantly pat[0]
        bus.load = 1'b1; bus.pat_in = p; bus.len_in = 3'd0;
        bus.start = 1'b1; bus.mode = 1'b0;
        cyc("len1.start", 1'b0, 1'b1, 1'b0, 3'd0);
        bus.load = 1'b0; bus.start = 1'b0;
        for (int k = 0; k < 4; k++)
            cyc($sformatf("len1.c%0d", k), p[0], 1'b1, 1'b0, 3'd0);
        bus.stop = 1'b1;
        cyc("len1.stop", 1'b0, 1'b0, 1'b0, 3'd0);
        bus.stop = 1'b0;

        // Length 1 one-shot: exactly one bit with done
        bus.start = 1'b1; bus.mode = 1'b1;
        cyc("len1o.start", 1'b0, 1'b1, 1'b0, 3'd0);
        bus.start = 1'b0;
        cyc("len1o.bit", p[0], 1'b0, 1'b1, 3'd0);
        cyc("len1o.after", 1'b0, 1'b0, 1'b0, 3'd0);

        // Async reset mid-run, then pattern must be back to 19
        bus.start = 1'b1; bus.mode = 1'b0;
        cyc("ar.start", 1'b0, 1'b1, 1'b0, 3'd0);
        bus.start = 1'b0;
        cyc("ar.run", p[0], 1'b1, 1'b0, 3'd0);
        #1 rst = 1'b0;
        #1;
        chk("ar.f", 32'(bus.f), 0);
        chk("ar.busy", 32'(bus.busy), 0);
        chk("ar.done", 32'(bus.done), 0);
        chk("ar.idx", 32'(bus.idx), 0);
        #1 rst = 1'b1;
        p = 8'h19;
        bus.start = 1'b1; bus.mode = 1'b0;
        cyc("ar.restart", 1'b0, 1'b1, 1'b0, 3'd0);
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++)
            cyc($sformatf("ar.bit%0d", k), p[k], 1'b1, 1'b0, 3'((k + 1) % 8));
        bus.stop = 1'b1;
        cyc("ar.stop", 1'b0, 1'b0, 1'b0, 3'd0);
        bus.stop = 1'b0;

`ifdef SEQ_GEN_FRAME_EN
        // Frame: length 4 continuous pulses with pat[3]
        bus.load = 1'b1; bus.pat_in = p; bus.len_in = 3'd3;
        bus.start = 1'b1; bus.mode = 1'b0;
        cyc("frm.start", 1'b0, 1'b1, 1'b0, 3'd0);
        chk("frm.start.frame", 32'(bus.frame), 0);
        bus.load = 1'b0; bus.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc($sformatf("frm.bit%0d", k), p[k % 4], 1'b1, 1'b0, 3'((k + 1) % 4));
            chk($sformatf("frm.frame%0d", k), 32'(bus.frame), 32'((k % 4) == 3));
        end
        bus.stop = 1'b1;
        cyc("frm.stop", 1'b0, 1'b0, 1'b0, 3'd0);
        bus.stop = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog: the directed sequence is a few hundred cycles at most
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end
endmodule
